// File: rtl/conv_feed_tx_if.sv
// conv_feed_tx_if: AXI-Stream bundle between the conv feeder and the conv engine.
interface conv_feed_tx_if #(parameter int DATA_W = 16);
  logic              tvalid;
  logic [DATA_W-1:0] tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic              tlast;
  logic              tready;
  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/conv_feed_tx.sv
// conv_feed_tx: streams a 9-word filter packet then a column-interleaved 3-row band from BRAM; CONV_FEED_STALL_CNT_EN adds stall_cycles.
module conv_feed_tx #(
  parameter int MEM_AW = 12,
  parameter int DATA_W = 16,
  parameter int COLS_W = 10
) (
  input  logic              M_AXIS_ACLK,
  input  logic              M_AXIS_ARESET,
  input  logic              start,
  input  logic [MEM_AW-1:0] cfg_filt_base,
  input  logic [MEM_AW-1:0] cfg_data_base,
  input  logic [COLS_W-1:0] cfg_cols,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef CONV_FEED_STALL_CNT_EN
  output logic [31:0]       stall_cycles,
`endif
  conv_feed_tx_if.master    m_axis
);
  typedef enum logic [1:0] {IDLE, FILT, DATA, DRAIN} state_t;
  state_t state;
  logic [MEM_AW-1:0] data_base, col_ptr;
  logic [COLS_W-1:0] cols, c;
  logic [1:0] r, count;
  logic rd_pend, rd_last, iss_last, pop, shift, wr0, wr1;
  logic [DATA_W-1:0] d0, d1;
  logic l0, l1;
  assign pop = count != 2'd0 && m_axis.tready;
  // Reads land one edge after issue, so a slot freed by this cycle's pop can be reused at once.
  assign mem_en = (state == FILT || state == DATA) &&
                  (({1'b0, count} + {2'b0, rd_pend}) < (pop ? 3'd3 : 3'd2));
  assign iss_last = state == FILT ? c == COLS_W'(8) : (r == 2'd2 && c + COLS_W'(1) == cols);
  assign shift = pop && count == 2'd2;
  assign wr0 = rd_pend && (count == 2'd0 || (pop && count == 2'd1));
  assign wr1 = rd_pend && ((count == 2'd1 && !pop) || shift);
  assign m_axis.tvalid = count != 2'd0;
  assign m_axis.tdata = d0;
  assign m_axis.tlast = l0;
  assign m_axis.tkeep = '1;
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      count <= 2'd0;
      rd_pend <= 1'b0;
      rd_last <= 1'b0;
      d0 <= '0;
      l0 <= 1'b0;
      d1 <= '0;
      l1 <= 1'b0;
      mem_addr <= '0;
      data_base <= '0;
      col_ptr <= '0;
      cols <= '0;
      c <= '0;
      r <= 2'd0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      rd_pend <= mem_en;
      rd_last <= iss_last;
      count <= count + {1'b0, rd_pend} - {1'b0, pop};
      if (shift) {l0, d0} <= {l1, d1};
      else if (wr0) {l0, d0} <= {rd_last, mem_rdata};
      if (wr1) {l1, d1} <= {rd_last, mem_rdata};
      case (state)
        IDLE: if (start) begin
          if (cfg_cols < COLS_W'(3)) err <= 1'b1;
          else begin
            state <= FILT;
            busy <= 1'b1;
            mem_addr <= cfg_filt_base;
            data_base <= cfg_data_base;
            cols <= cfg_cols;
            c <= '0;
          end
        end
        FILT: if (mem_en) begin
          if (iss_last) begin
            state <= DATA;
            mem_addr <= data_base;
            col_ptr <= data_base;
            c <= '0;
            r <= 2'd0;
          end else begin
            mem_addr <= mem_addr + MEM_AW'(1);
            c <= c + COLS_W'(1);
          end
        end
        DATA: if (mem_en) begin
          if (r == 2'd2) begin
            r <= 2'd0;
            c <= c + COLS_W'(1);
            col_ptr <= col_ptr + MEM_AW'(1);
            mem_addr <= col_ptr + MEM_AW'(1);
            if (iss_last) state <= DRAIN;
          end else begin
            r <= r + 2'd1;
            mem_addr <= mem_addr + MEM_AW'(cols);
          end
        end
        DRAIN: if (!rd_pend && (count == 2'd0 || (count == 2'd1 && pop))) begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
        end
      endcase
    end
  end
`ifdef CONV_FEED_STALL_CNT_EN
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET || (state == IDLE && start && cfg_cols >= COLS_W'(3))) stall_cycles <= '0;
    else if (busy && count != 2'd0 && !m_axis.tready && ~&stall_cycles) stall_cycles <= stall_cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_conv_feed_tx.sv
// tb_conv_feed_tx: scoreboard bench for conv_feed_tx with a 1-cycle BRAM model.
module tb_conv_feed_tx;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [11:0] cfg_filt_base = '0, cfg_data_base = '0;
  logic [9:0] cfg_cols = '0;
  logic busy, done, err, mem_en;
  logic [11:0] mem_addr;
  logic [15:0] mem_rdata;
`ifdef CONV_FEED_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif
  logic [15:0] mem [4096];
  logic [16:0] q [$];
  int errors = 0, checks = 0, nx;
  conv_feed_tx_if #(.DATA_W(16)) axis();
  conv_feed_tx #(.MEM_AW(12), .DATA_W(16), .COLS_W(10)) dut (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst), .start(start),
    .cfg_filt_base(cfg_filt_base), .cfg_data_base(cfg_data_base), .cfg_cols(cfg_cols),
    .busy(busy), .done(done), .err(err), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
`ifdef CONV_FEED_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .m_axis(axis));
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_tvalid"}, axis.tvalid, 0);
    chk({tag, "_tlast"}, axis.tlast, 0);
    chk({tag, "_tdata"}, axis.tdata, 0);
  endtask

  task automatic push_job(input logic [11:0] fb, input logic [11:0] db, input int cols);
    logic [11:0] a;
    for (int i = 0; i < 9; i++) begin
      a = fb + 12'(i);
      q.push_back({i == 8, mem[a]});
    end
    for (int cc = 0; cc < cols; cc++)
      for (int rr = 0; rr < 3; rr++) begin
        a = db + 12'(rr * cols + cc);
        q.push_back({rr == 2 && cc == cols - 1, mem[a]});
      end
  endtask

  // mode: 0 ready high, 1 toggling, 2 held low 20 cycles, 3 low 7 cycles; stop_at>=0 returns with that word pending
  task automatic job(input int mode, input int cols, input int stop_at, output int n);
    int first_v, last_x, done_at, stall_mem, err_seen;
    logic pv;
    logic [16:0] pd, e;
    first_v = -1; last_x = -1; done_at = -1; stall_mem = 0; err_seen = 0; pv = 1'b0; pd = '0; n = 0;
    cfg_filt_base = 12'h010; cfg_data_base = 12'h100; cfg_cols = 10'(cols); start = 1'b1;
    push_job(12'h010, 12'h100, cols);
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      start = (k == 5);
      if (k == 5) begin cfg_cols = 10'd2; cfg_filt_base = 12'hABC; cfg_data_base = 12'h777; end
      if (stop_at >= 0 && n == stop_at && axis.tvalid) begin
        axis.tready = 1'b0;
        return;
      end
      if (axis.tvalid && first_v < 0) first_v = k;
      axis.tready = (mode == 1) ? ((k % 2) == 1) :
                    (mode == 2) ? !(first_v >= 0 && k < first_v + 20) :
                    (mode == 3) ? !(first_v >= 0 && k >= first_v + 2 && k < first_v + 9) : 1'b1;
      #1;
      if (k == 1) begin
        chk("first_mem_en", mem_en, 1);
        chk("first_addr", mem_addr, 12'h010);
        chk("busy_after_start", busy, 1);
        chk("done_single_pulse", done, 0);
`ifdef CONV_FEED_STALL_CNT_EN
        chk("stall_cleared", stall_cycles, 0);
`endif
      end
      if (mode == 2 && first_v >= 0 && k < first_v + 20 && mem_en) stall_mem++;
      if (mode == 2 && first_v >= 0 && k == first_v + 10) chk("stall_word", {axis.tvalid, axis.tdata}, 17'h1_0001);
      if (err) err_seen++;
      if (pv) chk("hold", {axis.tvalid, axis.tlast, axis.tdata}, {1'b1, pd});
      pv = axis.tvalid && !axis.tready;
      pd = {axis.tlast, axis.tdata};
      if (axis.tvalid && axis.tready) begin
        e = (q.size() > 0) ? q.pop_front() : 17'bx;
        chk("word", {axis.tlast, axis.tdata}, e);
        n++;
        last_x = k;
      end
      if (done) begin
        done_at = k;
        chk("busy_at_done", busy, 0);
        break;
      end
    end
    chk("first_tvalid_cycle", first_v, 3);
    chk("done_after_last", done_at, last_x + 1);
    chk("word_count", n, 9 + 3 * cols);
    chk("queue_empty", q.size(), 0);
    chk("no_err_while_busy", err_seen, 0);
    if (mode == 0) chk("no_bubbles", last_x - first_v + 1, n);
    if (mode == 2) chk("mem_en_during_stall", stall_mem, 0);
  endtask

  initial begin
    for (int i = 0; i < 9; i++) mem[12'h010 + i] = 16'(i + 1);
    for (int i = 0; i < 12; i++) mem[12'h100 + i] = 16'(i);
    axis.tready = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    job(0, 4, -1, nx);
    job(1, 4, -1, nx);
    job(2, 4, -1, nx);
    @(negedge clk);
    cfg_cols = 10'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    @(negedge clk);
    chk("err_one_cycle", err, 0);
    nx = 0;
    repeat (5) begin
      if (axis.tvalid || busy || mem_en) nx++;
      @(negedge clk);
    end
    chk("no_activity_after_err", nx, 0);
    job(0, 3, -1, nx);
    job(0, 4, 13, nx);
    chk("words_before_reset", nx, 13);
    rst = 1'b1; start = 1'b1; cfg_cols = 10'd4;
    @(negedge clk);
    start = 1'b0;
    chk_idle("midreset");
    rst = 1'b0;
    axis.tready = 1'b1;
    q.delete();
    @(negedge clk);
    chk_idle("after_reset");
    job(0, 4, -1, nx);
`ifdef CONV_FEED_STALL_CNT_EN
    job(3, 4, -1, nx);
    chk("stall_cycles_at_done", stall_cycles, 7);
    @(negedge clk);
    chk("stall_cycles_hold", stall_cycles, 7);
    job(0, 4, -1, nx);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
